uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel half of the UART: samples the `rx` line with the shared 16× oversampling tick from `baud_rate_generator` and recovers 8N1 frames (start bit, NB_DATA data bits LSB first, one stop bit). It is the counterpart of `transmitter` and produces one parallel word plus a one-cycle done strobe per frame for the interface block. A stop-bit framing error is flagged alongside the word.

## Interface
- `NB_DATA`, 8, data bits per frame
- `SB_TICK`, 16, ticks counted for the stop bit
- `i_clock`  in  1  system clock, all logic on rising edge
- `i_reset`  in  1  asynchronous, active-low reset
- `i_tick`  in  1  one-cycle pulse at 16× baud, from `baud_rate_generator`
- `i_rx`  in  1  serial line, idle high
- `o_rx_data`  out  NB_DATA  last received word, held until next completed frame
- `o_rx_done`  out  1  one-cycle pulse: `o_rx_data` / `o_frame_error` just updated
- `o_frame_error`  out  1  stop bit sampled low on last frame, held like `o_rx_data`

## Operation
- States: IDLE, START, DATA, STOP. Tick counter `s` (4 bits), bit counter `n` (clog2(NB_DATA) bits), shift register `b` (NB_DATA bits).
- IDLE: on any clock with rx == 0, go to START with s = 0. Tick not required for detection.
- START: each tick: if s == 7, check rx. If rx == 0, go to DATA with s = 0, n = 0. If rx == 1, false start, return to IDLE with no output. Otherwise s++.
- DATA: each tick: if s == 15, shift right with rx into the MSB (b = {rx, b[NB_DATA-1:1]}) and set s = 0. Go to STOP when n == NB_DATA-1, otherwise n++. Otherwise s++.
- STOP: each tick: if s == SB_TICK-1, then o_rx_data = b, o_frame_error = ~rx, pulse o_rx_done, and go to IDLE. Otherwise s++.
- A frame error does not suppress delivery. The word is still presented and done still pulses.
- Sampling points fall at mid-bit: start bit at tick 8, then every 16 ticks. IDLE is re-entered at mid-stop-bit, so a back-to-back start edge is caught.
- Clock cycles without a tick leave state and all counters unchanged.
- Reset (any time, including mid-frame) forces IDLE, s = 0, n = 0, b = 0, o_rx_data = 0, o_rx_done = 0, o_frame_error = 0. The partial frame is discarded.

## Timing
- Registered outputs. o_rx_done is high for exactly the one clock following the tick that completes STOP. o_rx_data and o_frame_error are valid in that same cycle and remain stable until the next done pulse.
- Latency from the start-bit falling edge (as seen at the FSM input) to done: 8 + 16·NB_DATA + SB_TICK ticks, plus 1 clock. This is 152 ticks for the defaults.
- If rx falls in the same cycle that STOP completes, the edge is detected on the next clock in IDLE.
- No backpressure. A consumer that misses the done pulse loses nothing until the next frame overwrites the data.

## Configuration
- `UART_RECEIVER_SYNC_EN` defined: `i_rx` passes through a two-flop synchronizer (reset value 1) before the FSM. All detection is delayed by 2 clocks, and the tick-level latency is unchanged.
- Not defined: `i_rx` is used directly. Only legal when the source is already in the `i_clock` domain (e.g. the transmitter loopback in simulation).

## Structure
- Shared package `uart_pkg` holds the state encoding (IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11), the `OVERSAMPLE = 16` constant, and the NB_DATA default. `transmitter` uses the same package.
- One sub-module: `rx_synchronizer` (two-flop, reset to 1), instantiated only under `UART_RECEIVER_SYNC_EN`.
- The FSM, counters and shift register are flat in `uart_receiver`.

## Test plan
- Drive the frame for 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), 16 ticks per bit → a single o_rx_done pulse, o_rx_data = 0xA5, o_frame_error = 0.
- Loopback from `transmitter` sending 8'b10101010, sharing one `baud_rate_generator` → o_rx_data = 0xAA one clock after the transmitter's stop bit reaches mid-bit.
- Back-to-back frames 0x00 then 0xFF with no idle gap → two done pulses, 160 ticks apart, with data 0x00 then 0xFF.
- rx low for 3 ticks, then high → no done pulse, FSM back in IDLE, outputs unchanged.
- Frame 0x3C with the stop bit driven low → done pulses, o_rx_data = 0x3C, o_frame_error = 1. Frame error clears to 0 on the next good frame.
- Assert i_reset low during data bit 4 of a frame, release, then send 0x81 → no done from the aborted frame, all outputs 0 during reset, next done has o_rx_data = 0x81.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and framing constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_t;

  localparam int OVERSAMPLE      = 16;
  localparam int NB_DATA_DEFAULT = 8;

endpackage

// File: rtl/rx_synchronizer.sv
// Two-flop synchronizer for the serial line; resets to the idle (high) level.
module rx_synchronizer (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  logic meta;

  // Resample the asynchronous line twice; reset to 1 so no false start is seen.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver using a 16x oversampling tick; samples each bit at mid-bit.
// Optional input synchronizer enabled by defining UART_RECEIVER_SYNC_EN.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEFAULT,
  parameter int SB_TICK = OVERSAMPLE
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_rx_data,
  output logic               o_rx_done,
  output logic               o_frame_error
);

  localparam int              NW        = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic [3:0]      START_MID = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]      BIT_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]      STOP_LAST = 4'(SB_TICK - 1);
  localparam logic [NW-1:0]   N_LAST    = NW'(NB_DATA - 1);

  logic rx;

`ifdef UART_RECEIVER_SYNC_EN
  rx_synchronizer u_rx_sync (
    .clock   (i_clock),
    .reset_n (i_reset),
    .din     (i_rx),
    .dout    (rx)
  );
`else
  assign rx = i_rx;
`endif

  uart_state_t        state, state_next;
  logic [3:0]         s, s_next;
  logic [NW-1:0]      n, n_next;
  logic [NB_DATA-1:0] b, b_next;
  logic [NB_DATA-1:0] data_next;
  logic               done_next;
  logic               ferr_next;

  // State, counters, shift register and registered outputs; reset drops any partial frame.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state         <= IDLE;
      s             <= '0;
      n             <= '0;
      b             <= '0;
      o_rx_data     <= '0;
      o_rx_done     <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      state         <= state_next;
      s             <= s_next;
      n             <= n_next;
      b             <= b_next;
      o_rx_data     <= data_next;
      o_rx_done     <= done_next;
      o_frame_error <= ferr_next;
    end
  end

  // Frame sequencing: everything but start-edge detection advances only on a tick.
  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    b_next     = b;
    data_next  = o_rx_data;
    ferr_next  = o_frame_error;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx) begin
          state_next = START;
          s_next     = '0;
        end
      end
      START: begin
        if (i_tick) begin
          if (s == START_MID) begin
            s_next = '0;
            if (!rx) begin
              state_next = DATA;
              n_next     = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s + 4'd1;
          end
        end
      end
      DATA: begin
        if (i_tick) begin
          if (s == BIT_LAST) begin
            s_next = '0;
            b_next = {rx, b[NB_DATA-1:1]};
            if (n == N_LAST) begin
              state_next = STOP;
            end else begin
              n_next = n + NW'(1);
            end
          end else begin
            s_next = s + 4'd1;
          end
        end
      end
      STOP: begin
        if (i_tick) begin
          if (s == STOP_LAST) begin
            s_next     = '0;
            data_next  = b;
            ferr_next  = ~rx;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            s_next = s + 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed and random 8N1 frames, false
// start, framing error and mid-frame reset, against a frame-level reference model.
module tb_uart_receiver;

  localparam int NB_DATA   = 8;
  localparam int TICK_DIV  = 4;
  localparam int FRAME_LAT = 8 + 16 * NB_DATA + 16;

  logic               i_clock = 1'b0;
  logic               i_reset = 1'b0;
  logic               i_tick  = 1'b0;
  logic               i_rx    = 1'b1;
  logic [NB_DATA-1:0] o_rx_data;
  logic               o_rx_done;
  logic               o_frame_error;

  uart_receiver #(.NB_DATA(NB_DATA), .SB_TICK(16)) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_tick        (i_tick),
    .i_rx          (i_rx),
    .o_rx_data     (o_rx_data),
    .o_rx_done     (o_rx_done),
    .o_frame_error (o_frame_error)
  );

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    int         due;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] last_data = 8'h00;
  logic       last_ferr = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         ticks_seen = 0;
  int         div_cnt = 0;
  int         prev_done_tick = 0;
  int         last_done_tick = 0;

  // Free-running system clock.
  always #5 i_clock = ~i_clock;

  // Baud tick: one clock in every TICK_DIV, changed on the falling edge.
  initial begin
    forever begin
      @(negedge i_clock);
      div_cnt = (div_cnt + 1) % TICK_DIV;
      i_tick  = (div_cnt == 0);
    end
  end

  // Count ticks presented to the DUT at rising edges.
  always @(posedge i_clock) begin
    if (i_tick) ticks_seen <= ticks_seen + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every done pulse must match the oldest frame still owed by the model.
  always @(negedge i_clock) begin : monitor
    exp_t e;
    if (i_reset && o_rx_done === 1'b1) begin
      check("done_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("done_data", 32'(o_rx_data), 32'(e.data));
        check("done_ferr", 32'(o_frame_error), 32'(e.ferr));
        check("done_latency", ticks_seen, e.due);
        last_data      = e.data;
        last_ferr      = e.ferr;
        prev_done_tick = last_done_tick;
        last_done_tick = ticks_seen;
      end
    end
  end

  task automatic wait_until_tick(input int target);
    int budget;
    budget = 2000;
    while (ticks_seen < target && budget > 0) begin
      @(negedge i_clock);
      budget--;
    end
    if (ticks_seen < target) check("tick_timeout", ticks_seen, target);
  endtask

  task automatic begin_start_bit(output int t0);
    @(negedge i_clock);
    i_rx = 1'b0;
    @(negedge i_clock);
    t0 = ticks_seen;
  endtask

  task automatic apply_frame(input logic [7:0] data, input logic stop_bit);
    int t0;
    begin_start_bit(t0);
    exp_q.push_back('{data, ~stop_bit, t0 + FRAME_LAT});
    for (int k = 0; k < 8; k++) begin
      wait_until_tick(t0 + 16 * (k + 1));
      i_rx = data[k];
    end
    wait_until_tick(t0 + 144);
    i_rx = stop_bit;
    wait_until_tick(t0 + FRAME_LAT);
    i_rx = 1'b1;
    wait_until_tick(t0 + 160);
  endtask

  task automatic check_output();
    check("pending_frames", exp_q.size(), 0);
    check("held_data", 32'(o_rx_data), 32'(last_data));
    check("held_ferr", 32'(o_frame_error), 32'(last_ferr));
    check("done_low", 32'(o_rx_done), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("reset_data", 32'(o_rx_data), 32'd0);
    check("reset_done", 32'(o_rx_done), 32'd0);
    check("reset_ferr", 32'(o_frame_error), 32'd0);
  endtask

  // Directed sequence followed by randomized frames.
  initial begin : apply_stimulus
    int         t0;
    logic [7:0] rdata;
    logic       rstop;

    repeat (5) @(negedge i_clock);
    check_reset_outputs();
    i_reset = 1'b1;
    wait_until_tick(ticks_seen + 5);

    $display("[TB] frame 0xA5");
    apply_frame(8'hA5, 1'b1);
    check_output();

    $display("[TB] back-to-back 0x00, 0xFF");
    apply_frame(8'h00, 1'b1);
    apply_frame(8'hFF, 1'b1);
    check_output();
    check("b2b_spacing", last_done_tick - prev_done_tick, 160);

    $display("[TB] false start");
    begin_start_bit(t0);
    wait_until_tick(t0 + 3);
    i_rx = 1'b1;
    wait_until_tick(t0 + 30);
    check_output();

    $display("[TB] framing error then good frame");
    apply_frame(8'h3C, 1'b0);
    check_output();
    apply_frame(8'h5A, 1'b1);
    check_output();

    $display("[TB] reset during data bit 4");
    begin_start_bit(t0);
    wait_until_tick(t0 + 16);
    i_rx = 1'b1;
    wait_until_tick(t0 + 88);
    i_reset = 1'b0;
    @(negedge i_clock);
    check_reset_outputs();
    last_data = 8'h00;
    last_ferr = 1'b0;
    i_rx = 1'b1;
    repeat (6) @(negedge i_clock);
    check_reset_outputs();
    i_reset = 1'b1;
    wait_until_tick(ticks_seen + 40);
    check_output();
    apply_frame(8'h81, 1'b1);
    check_output();

    $display("[TB] random frames");
    for (int i = 0; i < 8; i++) begin
      rdata = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 3) != 0);
      apply_frame(rdata, rstop);
      wait_until_tick(ticks_seen + $urandom_range(0, 12));
      check_output();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
